multicycle_core: RTL and testbench
==================================

Name: multicycle_core

Overview:
- Multi-cycle RV32I-subset processor core with a finite state machine (FSM): fetch, decode, execute, memory and writeback each take their own state.
- Instruction memory and data memory are external, on separate req/ack handshakes that tolerate any number of wait cycles.
- Successor to the single-cycle core top. Adds a parametrised reset vector, a parametrised register count (RV32E/RV32I), memory wait-state handling, illegal-instruction halt and a retire strobe.
- Sits between the system instruction ROM/RAM and the data RAM.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] are ignored and forced to 0.
- NUM_REGS, 32, architectural register count, 16 or 32. Any rs1/rs2/rd index >= NUM_REGS is illegal.

Ports:
- CLOCK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- imem_req  out  1  instruction fetch request, held until imem_ack.
- imem_addr  out  32  fetch address (= PC).
- imem_ack  in  1  instruction valid this cycle.
- imem_rdata  in  32  instruction word.
- dmem_re  out  1  load request, held until dmem_ack.
- dmem_we  out  1  store request, held until dmem_ack.
- dmem_addr  out  32  data word address, bits [1:0] forced to 00.
- dmem_wdata  out  32  store data (rs2).
- dmem_ack  in  1  data access complete; for loads, dmem_rdata is valid this cycle.
- dmem_rdata  in  32  load data.
- PC  out  32  current program counter.
- retire  out  1  one-cycle pulse per completed instruction.
- illegal  out  1  sticky halt flag.

Behaviour:
- Reset (RST=1 at an edge):
  - State goes to FETCH; PC=RESET_PC; illegal=0, retire=0.
  - imem_req, dmem_re and dmem_we are deasserted in that same cycle.
  - Register file is not cleared; x0 always reads 0.
  - RST overrides every state, including a pending handshake. The abandoned request is dropped with no retire.
- States: FETCH, DECODE, EXECUTE, MEM, WB, HALT.
- FETCH:
  - imem_req=1 with imem_addr=PC.
  - On imem_ack: latch IR, go to DECODE. Otherwise stay.
- DECODE:
  - Latch A=rs1 and B=rs2 from the register file, plus the immediate (I/S/B/U/J formats).
  - Illegal opcode/funct or register index >= NUM_REGS -> HALT.
- EXECUTE:
  - ALU result goes to ALUOut. A operand is PC (AUIPC, JAL), 0 (LUI) or rs1; B operand is imm or rs2.
  - Supported ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU and their immediate forms, LUI, AUIPC, LW, SW, BEQ, BNE, JAL.
  - Shift amount = B[4:0]. Arithmetic wraps modulo 2^32.
  - Next PC: branch taken -> PC+imm; JAL -> PC+imm with rd=PC+4; otherwise PC+4. Target bits [1:0] are forced to 0.
  - LW/SW -> MEM; everything else -> WB.
- MEM:
  - dmem_re (LW) or dmem_we (SW) is held together with dmem_addr and dmem_wdata until dmem_ack.
  - On ack: latch load data (MDR), go to WB.
  - dmem_re and dmem_we are never high together.
- WB:
  - Write rd (ALUOut, MDR or PC+4). Writes to rd=0 are discarded.
  - PC <= next PC; retire=1 for exactly this cycle; go to FETCH.
- HALT:
  - All requests low; illegal=1; PC holds the faulting address.
  - Only RST leaves HALT.
- Latency with zero-wait memories:
  - ALU/branch/JAL/LUI/AUIPC: 4 cycles.
  - LW/SW: 5 cycles.
  - Each memory wait cycle adds 1.
- Register file: one write port (WB) and two read ports; reads are combinational with no bypass, since the FSM serialises write and read.

Optional Feature:
- Macro: CORE_EXT_BRANCH_EN.
- Defined: BLT, BGE, BLTU and BGEU are decoded. Signed or unsigned compare of A vs B, same timing as BEQ.
- Undefined: those funct3 encodings under the BRANCH opcode are illegal -> HALT.

Test Plan:
- Reset with RESET_PC=32'h100 -> PC=0x100; imem_req=1 in the first cycle after RST falls.
- ADDI x1,x0,5; ADD x2,x1,x1; SW x2,8(x0) with zero-wait memories -> dmem_we=1, dmem_addr=8, dmem_wdata=10; 3 retire pulses in 13 cycles.
- LW x3,0(x0) with dmem_ack delayed 3 cycles, dmem_rdata=0xDEADBEEF; then SW x3,4(x0) -> dmem_wdata=0xDEADBEEF; retire for the LW occurs exactly 3 cycles later than with zero wait.
- BEQ x0,x0,-8 at PC=0x20 -> next imem_addr=0x18. BNE x0,x0,+8 -> next imem_addr=0x24.
- Instruction 32'h0000_0000, and with NUM_REGS=16 ADDI x20,x0,1 -> illegal=1, PC holds, no requests for 20 cycles; RST clears illegal.
- RST asserted while dmem_re is pending -> next cycle dmem_re=0, PC=RESET_PC, no retire pulse.

Source files
------------

// File: rtl/multicycle_core_if.sv
// Instruction-fetch and data-memory req/ack bus between multicycle_core (master)
// and the external instruction ROM/RAM and data RAM (slave).
interface multicycle_core_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_re;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output dmem_re, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  dmem_re, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core, FSM FETCH/DECODE/EXECUTE/MEM/WB/HALT.
// Define CORE_EXT_BRANCH_EN to also decode BLT/BGE/BLTU/BGEU.
module multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              CLOCK,
  input  logic              RST,
  multicycle_core_if.master bus,
  output logic [31:0]       PC,
  output logic              retire,
  output logic              illegal
);
  localparam int unsigned AW   = $clog2(NUM_REGS);
  localparam logic [5:0]  NREG = 6'(NUM_REGS);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT
  } state_t;

  state_t r_state, w_next;

  logic [31:0] r_pc, r_ir, r_a, r_b, r_imm, r_aluout, r_mdr, r_npc;
  logic [31:0] r_regs [NUM_REGS];

  logic [6:0] w_opcode, w_f7;
  logic [4:0] w_rd, w_rs1, w_rs2;
  logic [2:0] w_f3;

  assign w_opcode = r_ir[6:0];
  assign w_rd     = r_ir[11:7];
  assign w_f3     = r_ir[14:12];
  assign w_rs1    = r_ir[19:15];
  assign w_rs2    = r_ir[24:20];
  assign w_f7     = r_ir[31:25];

  function automatic logic reg_ok(input logic [4:0] idx);
    return {1'b0, idx} < NREG;
  endfunction

  logic        w_is_r, w_is_i, w_is_lui, w_is_auipc, w_is_jal;
  logic        w_is_load, w_is_store, w_is_br;
  logic        w_use_rs1, w_use_rs2, w_use_rd, w_funct_ok, w_legal;
  logic [31:0] w_imm;

  always_comb begin
    w_is_r     = (w_opcode == OP_R);
    w_is_i     = (w_opcode == OP_I);
    w_is_lui   = (w_opcode == OP_LUI);
    w_is_auipc = (w_opcode == OP_AUIPC);
    w_is_jal   = (w_opcode == OP_JAL);
    w_is_load  = (w_opcode == OP_LOAD);
    w_is_store = (w_opcode == OP_STORE);
    w_is_br    = (w_opcode == OP_BR);
    w_use_rs1  = w_is_r | w_is_i | w_is_load | w_is_store | w_is_br;
    w_use_rs2  = w_is_r | w_is_store | w_is_br;
    w_use_rd   = w_is_r | w_is_i | w_is_lui | w_is_auipc | w_is_jal | w_is_load;
    w_funct_ok = 1'b0;
    w_imm      = '0;
    case (w_opcode)
      OP_R: w_funct_ok = (w_f7 == 7'b0000000) ||
                         ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
      OP_I: begin
        w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
        case (w_f3)
          3'b001:  w_funct_ok = (w_f7 == 7'b0000000);
          3'b101:  w_funct_ok = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
          default: w_funct_ok = 1'b1;
        endcase
      end
      OP_LUI, OP_AUIPC: begin
        w_funct_ok = 1'b1;
        w_imm      = {r_ir[31:12], 12'b0};
      end
      OP_JAL: begin
        w_funct_ok = 1'b1;
        w_imm      = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
      end
      OP_LOAD: begin
        w_funct_ok = (w_f3 == 3'b010);
        w_imm      = {{20{r_ir[31]}}, r_ir[31:20]};
      end
      OP_STORE: begin
        w_funct_ok = (w_f3 == 3'b010);
        w_imm      = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      end
      OP_BR: begin
`ifdef CORE_EXT_BRANCH_EN
        w_funct_ok = (w_f3 != 3'b010) && (w_f3 != 3'b011);
`else
        w_funct_ok = (w_f3 == 3'b000) || (w_f3 == 3'b001);
`endif
        w_imm      = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
      end
      default: ;
    endcase
    w_legal = w_funct_ok &&
              (!w_use_rs1 || reg_ok(w_rs1)) &&
              (!w_use_rs2 || reg_ok(w_rs2)) &&
              (!w_use_rd  || reg_ok(w_rd));
  end

  // Only the low AW index bits address the file; wider indices never get past DECODE.
  logic [31:0] w_rs1_val, w_rs2_val;
  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_regs[w_rs1[AW-1:0]];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_regs[w_rs2[AW-1:0]];

  logic [31:0] w_op_a, w_op_b, w_alu, w_pc4, w_npc, w_wb_val;
  logic [2:0]  w_alu_f3;
  logic        w_alt, w_taken;

  always_comb begin
    w_op_a = r_a;
    if (w_is_auipc || w_is_jal) w_op_a = r_pc;
    else if (w_is_lui)          w_op_a = '0;
    w_op_b   = (w_is_r || w_is_br) ? r_b : r_imm;
    w_alu_f3 = (w_is_r || w_is_i) ? w_f3 : 3'b000;
    w_alt    = w_f7[5] && (w_is_r || (w_is_i && (w_f3 == 3'b101)));
    w_alu    = '0;
    case (w_alu_f3)
      3'b000: w_alu = w_alt ? (w_op_a - w_op_b) : (w_op_a + w_op_b);
      3'b001: w_alu = w_op_a << w_op_b[4:0];
      3'b010: w_alu = {31'b0, $signed(w_op_a) < $signed(w_op_b)};
      3'b011: w_alu = {31'b0, w_op_a < w_op_b};
      3'b100: w_alu = w_op_a ^ w_op_b;
      3'b101: w_alu = w_alt ? $unsigned($signed(w_op_a) >>> w_op_b[4:0])
                            : (w_op_a >> w_op_b[4:0]);
      3'b110: w_alu = w_op_a | w_op_b;
      3'b111: w_alu = w_op_a & w_op_b;
      default: ;
    endcase

    w_taken = 1'b0;
    case (w_f3)
      3'b000: w_taken = (r_a == r_b);
      3'b001: w_taken = (r_a != r_b);
`ifdef CORE_EXT_BRANCH_EN
      3'b100: w_taken = ($signed(r_a) <  $signed(r_b));
      3'b101: w_taken = ($signed(r_a) >= $signed(r_b));
      3'b110: w_taken = (r_a <  r_b);
      3'b111: w_taken = (r_a >= r_b);
`endif
      default: ;
    endcase
    w_taken = w_taken && w_is_br;

    w_pc4    = r_pc + 32'd4;
    w_npc    = (w_taken || w_is_jal) ? ((r_pc + r_imm) & ~32'd3) : w_pc4;
    w_wb_val = w_is_load ? r_mdr : (w_is_jal ? w_pc4 : r_aluout);
  end

  always_ff @(posedge CLOCK) begin
    if (RST) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  logic w_imem_req, w_dmem_re, w_dmem_we;

  // Requests and retire are gated by RST so a pending handshake drops in the reset cycle.
  always_comb begin
    w_next     = r_state;
    w_imem_req = 1'b0;
    w_dmem_re  = 1'b0;
    w_dmem_we  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = !RST;
        if (bus.imem_ack) w_next = S_DECODE;
      end
      S_DECODE:  w_next = w_legal ? S_EXECUTE : S_HALT;
      S_EXECUTE: w_next = (w_is_load || w_is_store) ? S_MEM : S_WB;
      S_MEM: begin
        w_dmem_re = w_is_load  && !RST;
        w_dmem_we = w_is_store && !RST;
        if (bus.dmem_ack) w_next = S_WB;
      end
      S_WB: begin
        retire = !RST;
        w_next = S_FETCH;
      end
      S_HALT:  illegal = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RST) begin
      r_pc <= {RESET_PC[31:2], 2'b00};
    end else begin
      case (r_state)
        S_FETCH:   if (bus.imem_ack) r_ir <= bus.imem_rdata;
        S_DECODE: begin
          r_a   <= w_rs1_val;
          r_b   <= w_rs2_val;
          r_imm <= w_imm;
        end
        S_EXECUTE: begin
          r_aluout <= w_alu;
          r_npc    <= w_npc;
        end
        S_MEM:     if (bus.dmem_ack) r_mdr <= bus.dmem_rdata;
        S_WB:      r_pc <= r_npc;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RST && (r_state == S_WB) && w_use_rd && (w_rd != 5'd0))
      r_regs[w_rd[AW-1:0]] <= w_wb_val;
  end

  assign bus.imem_req   = w_imem_req;
  assign bus.imem_addr  = r_pc;
  assign bus.dmem_re    = w_dmem_re;
  assign bus.dmem_we    = w_dmem_we;
  assign bus.dmem_addr  = {r_aluout[31:2], 2'b00};
  assign bus.dmem_wdata = r_b;
  assign PC             = r_pc;
endmodule

// File: tb/tb_multicycle_core.sv
// Directed-program bench for multicycle_core with a scoreboard of expected
// fetch / store / retire events checked by an independent monitor.
module tb_multicycle_core;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  localparam int EV_FETCH  = 0;
  localparam int EV_STORE  = 1;
  localparam int EV_RETIRE = 2;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } ev_t;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        retire;
  logic        illegal;

  multicycle_core_if bus ();

  multicycle_core #(
    .RESET_PC (32'h0000_0100),
    .NUM_REGS (16)
  ) dut (
    .CLOCK   (clk),
    .RST     (rst),
    .bus     (bus),
    .PC      (pc),
    .retire  (retire),
    .illegal (illegal)
  );

  logic [31:0] imem [1024];
  logic [31:0] dmem [64];
  int          lwait;
  int          dcnt;
  int          cyc;
  ev_t         q [$];
  int          rt [64];
  int          nret;
  int          n_tests;
  int          n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Zero-wait instruction memory; loads wait lwait cycles, stores ack at once.
  assign bus.imem_ack   = bus.imem_req;
  assign bus.imem_rdata = imem[bus.imem_addr[11:2]];
  assign bus.dmem_ack   = bus.dmem_we || (bus.dmem_re && (dcnt >= lwait));
  assign bus.dmem_rdata = dmem[bus.dmem_addr[7:2]];

  always @(posedge clk) begin
    dcnt <= (bus.dmem_re && !bus.dmem_ack) ? dcnt + 1 : 0;
    cyc  <= rst ? 0 : cyc + 1;
    if (bus.dmem_we && bus.dmem_ack) dmem[bus.dmem_addr[7:2]] <= bus.dmem_wdata;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void observe(int kind, logic [31:0] a, logic [31:0] b);
    ev_t e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d addr %h data %h expected none", kind, a, b);
    end else begin
      e = q.pop_front();
      check("ev_kind", 32'(kind), 32'(e.kind));
      check(kind == EV_FETCH ? "fetch_addr" : (kind == EV_STORE ? "store_addr" : "retire_pc"), a, e.a);
      if (kind == EV_STORE) check("store_data", b, e.b);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dmem_re && bus.dmem_we) begin
        n_tests++;
        n_fail++;
        $display("FAIL re_we_exclusive: got re=1 we=1 expected at most one");
      end
      if (bus.imem_req && bus.imem_ack) observe(EV_FETCH, bus.imem_addr, '0);
      if (bus.dmem_we && bus.dmem_ack)  observe(EV_STORE, bus.dmem_addr, bus.dmem_wdata);
      if (retire) begin
        observe(EV_RETIRE, pc, '0);
        if (nret < 64) rt[nret] = cyc;
        nret++;
      end
    end
  end

  function automatic void push(int kind, logic [31:0] a, logic [31:0] b);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    q.push_back(e);
  endfunction

  function automatic void exp_alu(logic [31:0] p);
    push(EV_FETCH, p, '0);
    push(EV_RETIRE, p, '0);
  endfunction

  function automatic void exp_sw(logic [31:0] p, logic [31:0] addr, logic [31:0] data);
    push(EV_FETCH, p, '0);
    push(EV_STORE, addr, data);
    push(EV_RETIRE, p, '0);
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), OP_R};
  endfunction

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] op);
    logic [31:0] v;
    v = imm20;
    return {v[19:0], 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
  endfunction

  function automatic void put(logic [31:0] addr, logic [31:0] ins);
    imem[addr[11:2]] = ins;
  endfunction

  function automatic void clear_imem();
    for (int i = 0; i < 1024; i++) imem[i] = '0;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h100);
    check("rst_reqs_low", {29'b0, bus.imem_req, bus.dmem_re, bus.dmem_we}, '0);
    check("rst_flags", {30'b0, illegal, retire}, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("first_req", {31'b0, bus.imem_req}, 32'd1);
  endtask

  task automatic wait_halt(logic [31:0] exp_pc);
    logic bad;
    for (int i = 0; i < 600 && !illegal; i++) @(negedge clk);
    check("halt_reached", {31'b0, illegal}, 32'd1);
    check("halt_pc", pc, exp_pc);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      bad = bad | bus.imem_req | bus.dmem_re | bus.dmem_we | retire | (pc != exp_pc) | !illegal;
    end
    check("halt_quiet", {31'b0, bad}, '0);
    check("sb_drained", q.size(), 0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    nret    = 0;
    lwait   = 0;
    dcnt    = 0;
    cyc     = 0;
    rst     = 1'b1;
    for (int i = 0; i < 64; i++) dmem[i] = '0;
    dmem[0] = 32'hDEAD_BEEF;

    // Program A: ALU, load with wait states, stores, branches, JAL, then illegal word.
    clear_imem();
    put(32'h100, enc_i(5, 0, 0, 1, OP_I));              // ADDI x1,x0,5
    put(32'h104, enc_r(0, 1, 1, 0, 2));                 // ADD  x2,x1,x1
    put(32'h108, enc_s(8, 2, 0));                       // SW   x2,8(x0)
    put(32'h10C, enc_i(0, 0, 2, 3, OP_LOAD));           // LW   x3,0(x0)
    put(32'h110, enc_s(4, 3, 0));                       // SW   x3,4(x0)
    put(32'h114, enc_j(-248, 0));                       // JAL  x0,0x1C
    put(32'h01C, enc_b(8, 0, 0, 1));                    // BNE  x0,x0,+8
    put(32'h020, enc_b(-8, 0, 0, 0));                   // BEQ  x0,x0,-8
    put(32'h018, enc_j(32'h1E8, 5));                    // JAL  x5,0x200
    put(32'h200, enc_r(32, 3, 1, 0, 6));                // SUB  x6,x1,x3
    put(32'h204, enc_r(32, 1, 3, 5, 7));                // SRA  x7,x3,x1
    put(32'h208, enc_r(0, 3, 1, 3, 8));                 // SLTU x8,x1,x3
    put(32'h20C, enc_r(0, 3, 1, 2, 9));                 // SLT  x9,x1,x3
    put(32'h210, enc_i(-1, 1, 4, 10, OP_I));            // XORI x10,x1,-1
    put(32'h214, enc_u(32'h12345, 11, OP_LUI));         // LUI  x11,0x12345
    put(32'h218, enc_u(1, 12, OP_AUIPC));               // AUIPC x12,1
    put(32'h21C, enc_i(28, 3, 5, 13, OP_I));            // SRLI x13,x3,28
    put(32'h220, enc_s(16, 6, 0));
    put(32'h224, enc_s(20, 7, 0));
    put(32'h228, enc_s(24, 8, 0));
    put(32'h22C, enc_s(28, 9, 0));
    put(32'h230, enc_s(32, 10, 0));
    put(32'h234, enc_s(36, 11, 0));
    put(32'h238, enc_s(40, 12, 0));
    put(32'h23C, enc_s(44, 13, 0));
    put(32'h240, enc_s(14, 5, 0));                      // SW x5,14(x0) -> word 12

    exp_alu(32'h100);
    exp_alu(32'h104);
    exp_sw (32'h108, 32'd8, 32'd10);
    exp_alu(32'h10C);
    exp_sw (32'h110, 32'd4, 32'hDEAD_BEEF);
    exp_alu(32'h114);
    exp_alu(32'h01C);
    exp_alu(32'h020);
    exp_alu(32'h018);
    for (int i = 0; i < 8; i++) exp_alu(32'h200 + 32'(4 * i));
    exp_sw (32'h220, 32'd16, 32'h2152_4116);
    exp_sw (32'h224, 32'd20, 32'hFEF5_6DF7);
    exp_sw (32'h228, 32'd24, 32'h0000_0001);
    exp_sw (32'h22C, 32'd28, 32'h0000_0000);
    exp_sw (32'h230, 32'd32, 32'hFFFF_FFFA);
    exp_sw (32'h234, 32'd36, 32'h1234_5000);
    exp_sw (32'h238, 32'd40, 32'h0000_1218);
    exp_sw (32'h23C, 32'd44, 32'h0000_000D);
    exp_sw (32'h240, 32'd12, 32'h0000_001C);
    push(EV_FETCH, 32'h244, '0);

    lwait = 3;
    do_reset();
    wait_halt(32'h244);
    check("retire0_cycle", 32'(rt[0]), 32'd3);
    check("retire2_cycle", 32'(rt[2]), 32'd12);
    check("lw_retire_gap", 32'(rt[3] - rt[2]), 32'd8);

    // Program B: destination index beyond NUM_REGS halts at decode.
    lwait = 0;
    clear_imem();
    put(32'h100, enc_i(1, 0, 0, 20, OP_I));             // ADDI x20,x0,1
    push(EV_FETCH, 32'h100, '0);
    do_reset();
    wait_halt(32'h100);

    // Program C: BLTU x0,x1,+8 (x1 survives reset), then an illegal word.
    clear_imem();
    put(32'h100, enc_b(8, 1, 0, 6));
`ifdef CORE_EXT_BRANCH_EN
    exp_alu(32'h100);
    push(EV_FETCH, 32'h108, '0);
    do_reset();
    wait_halt(32'h108);
`else
    push(EV_FETCH, 32'h100, '0);
    do_reset();
    wait_halt(32'h100);
`endif

    // Program D: reset lands while a load is still waiting for dmem_ack.
    clear_imem();
    put(32'h100, enc_i(0, 0, 0, 0, OP_I));              // NOP
    put(32'h104, enc_i(0, 0, 2, 4, OP_LOAD));           // LW x4,0(x0)
    exp_alu(32'h100);
    push(EV_FETCH, 32'h104, '0);
    lwait = 100;
    do_reset();
    for (int i = 0; i < 50 && !bus.dmem_re; i++) @(negedge clk);
    check("lw_pending", {31'b0, bus.dmem_re}, 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_drop_re", {31'b0, bus.dmem_re}, '0);
    check("rst_drop_pc", pc, 32'h100);
    check("rst_drop_retire", {31'b0, retire}, '0);
    repeat (3) @(negedge clk);
    check("sb_drained_d", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
